// File: rtl/uart_tx_periph_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets, STATUS bit
// positions, bus size codes and serializer state encodings.
package uart_tx_periph_pkg;

  // Peripheral base address and word offsets within it (addr[3:2]).
  localparam logic [31:0] UART_BASE_ADDR = 32'h1000_0000;
  localparam logic [1:0]  UART_TXDATA    = 2'd0;
  localparam logic [1:0]  UART_STATUS    = 2'd1;
  localparam logic [1:0]  UART_BAUD      = 2'd2;
  localparam logic [1:0]  UART_RSVD      = 2'd3;

  localparam int STAT_FULL   = 0;
  localparam int STAT_EMPTY  = 1;
  localparam int STAT_BUSY   = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_IRQ_EN = 4;

  // funct3 access-size codes carried on i_wb_sel.
  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] MIN_DIV = 16'd4;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

endpackage

// File: rtl/uart_tx_periph_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-around pointers; a push while full is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pop_ok   = i_pop && (count_q != '0);
    push_ok  = i_push && ((count_q != FULL_COUNT) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count define
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_full  = (count_q == FULL_COUNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/uart_tx_periph.sv
// Wishbone-slave 8N1 UART transmitter with TX FIFO, STATUS and programmable baud divisor.
// Optional interrupt output and STATUS[4] enable when UART_TX_IRQ_EN is defined.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_stb,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_sel,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_uart_tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH);

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] baud_q, baud_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        irq_en_bit;
`ifdef UART_TX_IRQ_EN
  logic        irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
`endif

  logic        wr_en, rd_en, push_req;
  logic [1:0]  reg_sel;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_rdata;
  logic [CW:0] fifo_level;
  logic [31:0] status_word;
  logic        unused_bits;

  assign wr_en    = i_wb_stb && i_wb_we;
  assign rd_en    = i_wb_stb && !i_wb_we;
  assign reg_sel  = i_wb_addr[3:2];
  assign push_req = wr_en && (reg_sel == UART_TXDATA);

  // Size code and undecoded address/data bits carry no meaning for this slave.
  assign unused_bits = ^{i_wb_addr[31:4], i_wb_addr[1:0], i_wb_data[31:16], i_wb_sel, fifo_level};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_req),
    .i_wdata (i_wb_data[7:0]),
    .i_pop   (fifo_pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_level)
  );

`ifdef UART_TX_IRQ_EN
  assign irq_en_bit = irq_en_q;
`else
  assign irq_en_bit = 1'b0;
`endif

  always_comb begin
    status_word              = '0;
    status_word[STAT_FULL]   = fifo_full;
    status_word[STAT_EMPTY]  = fifo_empty;
    status_word[STAT_BUSY]   = (state_q != ST_IDLE);
    status_word[STAT_OVF]    = ovf_q;
    status_word[STAT_IRQ_EN] = irq_en_bit;
  end

  // Bus side: single-cycle ack, registered read data, register writes.
  always_comb begin
    ack_d   = i_wb_stb;
    rdata_d = '0;
    baud_d  = baud_q;
    ovf_d   = ovf_q;
`ifdef UART_TX_IRQ_EN
    irq_en_d = irq_en_q;
`endif
    if (rd_en) begin
      case (reg_sel)
        UART_STATUS: rdata_d = status_word;
        UART_BAUD:   rdata_d = {16'h0000, baud_q};
        default:     rdata_d = '0;
      endcase
    end
    if (wr_en) begin
      case (reg_sel)
        UART_STATUS: begin
          if (i_wb_data[STAT_OVF]) ovf_d = 1'b0;
`ifdef UART_TX_IRQ_EN
          irq_en_d = i_wb_data[STAT_IRQ_EN];
`endif
        end
        UART_BAUD: baud_d = clamp_div(i_wb_data[15:0]);
        default:   ;
      endcase
    end
    // A push into a full FIFO is dropped unless the serializer frees a slot this cycle.
    if (push_req && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Serializer: each bit lasts baud_q clocks, latched when the bit starts, so a divisor
  // change only affects bits that begin after the write.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = baud_q - 16'd1;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          cnt_d     = baud_q - 16'd1;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = baud_q - 16'd1;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

`ifdef UART_TX_IRQ_EN
  always_comb begin
    irq_d = irq_en_q && ((fifo_empty && (state_q == ST_IDLE)) || ovf_q);
  end
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      baud_q    <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_IRQ_EN
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_IRQ_EN
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign o_uart_tx  = tx_q;
`ifdef UART_TX_IRQ_EN
  assign o_irq      = irq_q;
`endif

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: expected line waveforms are computed from the
// 8N1 frame rules (start 0, data LSB first, stop 1, BAUD clocks per bit).
module tb_uart_tx_periph;

  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, we;
  logic [31:0] addr, wdata;
  logic [2:0]  sel;
  logic [31:0] rdata;
  logic        ack, stall, tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
  logic        irq_hist [HMAX];
`endif

  int   total = 0;
  int   bad   = 0;
  int   edge_cnt = 0;
  logic tx_hist [HMAX];
  logic [7:0] exp_q [$];

  uart_tx_periph #(
    .FIFO_DEPTH  (16),
    .DEFAULT_DIV (16'd868)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_wb_stb   (stb),
    .i_wb_addr  (addr),
    .i_wb_data  (wdata),
    .i_wb_we    (we),
    .i_wb_sel   (sel),
    .o_wb_data  (rdata),
    .o_wb_ack   (ack),
    .o_wb_stall (stall),
    .o_uart_tx  (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .o_irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  // tx_hist[k] is the line value during the cycle following rising edge k.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) begin
    if (edge_cnt < HMAX) begin
      tx_hist[edge_cnt] = tx;
`ifdef UART_TX_IRQ_EN
      irq_hist[edge_cnt] = irq;
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk_addr(input logic [1:0] r);
    logic [31:0] a;
    a      = $urandom();
    a[3:2] = r;
    a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic wait_past(input int target);
    while (edge_cnt <= target) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d, output int e0);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = mk_addr(r); wdata = d; sel = 3'b010;
    e0 = edge_cnt + 1;
    @(negedge clk);
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL write_ack reg=%0d: got %b want 1", r, ack);
    end
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; addr = mk_addr(r); wdata = $urandom(); sel = 3'b010;
    @(negedge clk);
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL read_ack reg=%0d: got %b want 1", r, ack);
    end
    d   = rdata;
    stb = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL read_idle reg=%0d: ack=%b data=%h want ack=0 data=0", r, ack, rdata);
    end
  endtask

  task automatic expect_read(input string name, input logic [1:0] r, input logic [31:0] want);
    logic [31:0] got;
    bus_read(r, got);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Compare the recorded line against back-to-back frames of exp_q starting at edge s.
  task automatic check_stream(input string name, input int s, input int b);
    int   n;
    int   errs;
    int   first_e;
    int   bitpos;
    logic want;
    logic [7:0] cur;
    n = exp_q.size();
    total++;
    if (tx_hist[s-1] !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_before: got %b want 1", name, tx_hist[s-1]);
    end
    for (int f = 0; f < n; f++) begin
      cur = exp_q[f];
      errs = 0;
      first_e = 0;
      for (int off = 0; off < 10*b; off++) begin
        bitpos = off / b;
        want = (bitpos == 0) ? 1'b0 : (bitpos == 9) ? 1'b1 : cur[bitpos-1];
        if (tx_hist[s + f*10*b + off] !== want) begin
          if (errs == 0) first_e = off;
          errs++;
        end
      end
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL %s frame%0d byte=%h: %0d wrong samples, first at offset %0d got %b",
                 name, f, cur, errs, first_e, tx_hist[s + f*10*b + first_e]);
      end
    end
    total++;
    if (tx_hist[s + n*10*b] !== 1'b1) begin
      bad++;
      $display("FAIL %s idle_after: got %b want 1", name, tx_hist[s + n*10*b]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 3'b010;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: tx=%b ack=%b data=%h stall=%b want 1 0 0 0", tx, ack, rdata, stall);
    end
`ifdef UART_TX_IRQ_EN
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
`endif
    rst = 1'b0;
    expect_read("reset_status", 2'd1, 32'h2);
    expect_read("reset_baud", 2'd2, 32'd868);
    expect_read("txdata_reads_zero", 2'd0, 32'h0);
    expect_read("reserved_reads_zero", 2'd3, 32'h0);
  endtask

  task automatic test_frame_a5;
    int e;
    int e0;
    logic [9:0] line;
    int errs;
    line = 10'b1_10100101_0;
    bus_write(2'd2, 32'd4, e);
    bus_write(2'd0, 32'hA5, e0);
    wait_past(e0 + 1 + 40);
    errs = 0;
    for (int k = 0; k < 40; k++)
      if (tx_hist[e0 + 1 + k] !== line[k/4]) errs++;
    total++;
    if (errs != 0 || tx_hist[e0] !== 1'b1 || tx_hist[e0 + 41] !== 1'b1) begin
      bad++;
      $display("FAIL frame_a5: %0d wrong samples, pre=%b post=%b", errs, tx_hist[e0], tx_hist[e0+41]);
    end
    expect_read("a5_status_after", 2'd1, 32'h2);
  endtask

  task automatic test_random_frames;
    int e;
    int e0;
    int b;
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      b = $urandom_range(4, 8);
      v = 8'($urandom());
      bus_write(2'd2, b, e);
      bus_write(2'd0, {$urandom(), v}, e0);
      exp_q.delete();
      exp_q.push_back(v);
      wait_past(e0 + 2 + 10*b);
      check_stream("rand_frame", e0 + 1, b);
      expect_read("rand_status_after", 2'd1, 32'h2);
    end
  endtask

  task automatic test_back_to_back;
    int e;
    int e0;
    int e1;
    bus_write(2'd2, 32'd4, e);
    bus_write(2'd0, 32'h00, e0);
    bus_write(2'd0, 32'hFF, e1);
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wait_past(e0 + 2 + 80);
    check_stream("two_frames_no_gap", e0 + 1, 4);
  endtask

  task automatic test_overflow;
    int e;
    int e0;
    logic [7:0] v;
    bus_write(2'd2, 32'd4, e);
    exp_q.delete();
    @(negedge clk);
    e0 = edge_cnt + 1;
    for (int i = 0; i < 18; i++) begin
      v = 8'($urandom());
      if (i < 17) exp_q.push_back(v);
      stb = 1'b1; we = 1'b1; addr = mk_addr(2'd0); wdata = {24'h0, v};
      @(negedge clk);
      total++;
      if (ack !== 1'b1) begin
        bad++;
        $display("FAIL burst_ack%0d: got %b want 1", i, ack);
      end
    end
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL burst_ack_single: got %b want 0", ack);
    end
    expect_read("ovf_status_full", 2'd1, 32'hD);
    bus_write(2'd1, 32'h8, e);
    expect_read("ovf_cleared", 2'd1, 32'h5);
    wait_past(e0 + 2 + 17*40);
    check_stream("seventeen_frames", e0 + 1, 4);
    expect_read("ovf_drained_status", 2'd1, 32'h2);
  endtask

  task automatic test_baud_clamp;
    int e;
    logic [15:0] v;
    bus_write(2'd2, 32'd1, e);
    expect_read("baud_clamp_1", 2'd2, 32'd4);
    bus_write(2'd2, 32'd0, e);
    expect_read("baud_clamp_0", 2'd2, 32'd4);
    bus_write(2'd2, 32'h1234, e);
    expect_read("baud_1234", 2'd2, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom());
      bus_write(2'd2, {16'hBEEF, v}, e);
      expect_read("baud_random", 2'd2, {16'h0, (v < 16'd4) ? 16'd4 : v});
    end
    bus_write(2'd3, 32'hFFFF_FFFF, e);
    expect_read("reserved_write_ignored", 2'd3, 32'h0);
    expect_read("status_after_reserved", 2'd1, 32'h2);
  endtask

  // Bits starting after the BAUD write edge use the new divisor; earlier ones the old one.
  task automatic test_baud_midframe;
    int e;
    int e0;
    int w;
    int t;
    int len;
    int errs;
    logic [7:0] v;
    logic want;
    v = 8'($urandom());
    bus_write(2'd2, 32'd4, e);
    bus_write(2'd0, {24'h0, v}, e0);
    repeat ($urandom_range(3, 20)) @(negedge clk);
    bus_write(2'd2, 32'd6, w);
    t = e0 + 1;
    errs = 0;
    wait_past(e0 + 1 + 60 + 2);
    for (int k = 0; k < 10; k++) begin
      len = (t > w) ? 6 : 4;
      want = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v[k-1];
      for (int j = 0; j < len; j++)
        if (tx_hist[t + j] !== want) errs++;
      t += len;
    end
    total++;
    if (errs != 0 || tx_hist[t] !== 1'b1) begin
      bad++;
      $display("FAIL baud_midframe byte=%h wr_edge_off=%0d: %0d wrong samples, end=%b",
               v, w - e0, errs, tx_hist[t]);
    end
  endtask

  task automatic test_reset_midframe;
    int e;
    int e0;
    bus_write(2'd2, 32'd4, e);
    bus_write(2'd0, 32'h55, e0);
    bus_write(2'd0, 32'h3C, e);
    wait_past(e0 + 1 + 8);
    total++;
    if (tx !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset_line: got %b want 0 (data bit1 of 0x55)", tx);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1 || ack !== 1'b0 || rdata !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: tx=%b ack=%b data=%h want 1 0 0", tx, ack, rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e = edge_cnt;
    expect_read("reset_mid_status", 2'd1, 32'h2);
    expect_read("reset_mid_baud", 2'd2, 32'd868);
    wait_past(e + 30);
    total++;
    for (int k = e; k <= e + 30; k++) begin
      if (tx_hist[k] !== 1'b1) begin
        bad++;
        $display("FAIL reset_queue_lost: line low at edge offset %0d", k - e);
        break;
      end
    end
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq;
    int e;
    int e0;
    int errs;
    bus_write(2'd2, 32'd4, e);
    bus_write(2'd1, 32'h10, e);
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_idle_enabled: got %b want 1", irq);
    end
    expect_read("irq_status_bit4", 2'd1, 32'h12);
    bus_write(2'd0, 32'h81, e0);
    wait_past(e0 + 44);
    errs = 0;
    for (int k = e0 + 1; k <= e0 + 41; k++)
      if (irq_hist[k] !== 1'b0) errs++;
    total++;
    if (irq_hist[e0] !== 1'b1 || errs != 0 || irq_hist[e0 + 42] !== 1'b1) begin
      bad++;
      $display("FAIL irq_during_frame: before=%b high_during=%0d after=%b want 1 0 1",
               irq_hist[e0], errs, irq_hist[e0 + 42]);
    end
  endtask
`else
  task automatic test_irq;
    int e;
    bus_write(2'd1, 32'h10, e);
    expect_read("irq_en_absent", 2'd1, 32'h2);
  endtask
`endif

  initial begin
    test_reset;
    test_frame_a5;
    test_random_frames;
    test_back_to_back;
    test_overflow;
    test_baud_clamp;
    test_baud_midframe;
    test_reset_midframe;
    test_irq;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
